// File: rtl/alu_defs.sv
// ============================================================================
// Module   : alu_defs
// Brief    : Function codes and state encoding shared by the bit-serial ALU
//            driver, the ALU_1bit slice and the ALU control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_defs;

  // Function codes (MIPS R-type funct field)
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Driver state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  // True for the five function codes the slice understands.
  function automatic logic is_legal_funct(input logic [5:0] f);
    return (f == FN_AND) || (f == FN_OR) || (f == FN_ADD) ||
           (f == FN_SUB) || (f == FN_SLT);
  endfunction

  // SUB and SLT run as A + ~B + 1, so the carry chain starts at 1.
  function automatic logic uses_borrow(input logic [5:0] f);
    return (f == FN_SUB) || (f == FN_SLT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ALU_1bit.sv
// ============================================================================
// Module   : ALU_1bit
// Brief    : Single-bit ALU slice. AND/OR are bitwise; ADD is a full adder;
//            SUB/SLT add the inverted B bit (the caller supplies cin=1 at
//            bit 0). SLT output here is the raw subtraction bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ALU_1bit
  import alu_defs::*;
(
  input  logic       dataA,
  input  logic       dataB,
  input  logic [5:0] Signal,
  input  logic       cin,
  output logic       dataOut,
  output logic       cout
);

  logic w_b;

  // Per-bit function select; arithmetic ops share one full adder.
  always_comb begin
    w_b     = dataB;
    dataOut = 1'b0;
    cout    = 1'b0;
    case (Signal)
      FN_AND: dataOut = dataA & dataB;
      FN_OR:  dataOut = dataA | dataB;
      FN_ADD, FN_SUB, FN_SLT: begin
        w_b     = (Signal == FN_ADD) ? dataB : ~dataB;
        dataOut = dataA ^ w_b ^ cin;
        cout    = (dataA & w_b) | (dataA & cin) | (w_b & cin);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/serial_alu_driver.sv
// ============================================================================
// Module   : serial_alu_driver
// Brief    : Issues one WIDTH-bit ALU operation as WIDTH single-bit steps
//            through one ALU_1bit slice, then forms SLT, zero and overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_alu_driver
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [5:0]       funct,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [5:0]       r_funct;
  logic             r_carry;
  logic             r_cin_msb;
  logic             r_illegal_wait;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_err;

  logic             w_bit_a;
  logic             w_bit_b;
  logic             w_slice_out;
  logic             w_slice_cout;
  logic             w_last;
  logic             w_v;
  logic [WIDTH-1:0] w_fin_result;
  logic             w_fin_ovf;

  assign w_bit_a = r_a[r_cnt];
  assign w_bit_b = r_b[r_cnt];
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  ALU_1bit u_slice (
    .dataA   (w_bit_a),
    .dataB   (w_bit_b),
    .Signal  (r_funct),
    .cin     (r_carry),
    .dataOut (w_slice_out),
    .cout    (w_slice_cout)
  );

  // Word-level result and overflow, valid while in FINAL.
  always_comb begin
    w_v          = r_cin_msb ^ r_carry;
    w_fin_result = r_work;
    w_fin_ovf    = 1'b0;
    case (r_funct)
      FN_SLT:         w_fin_result = {{(WIDTH-1){1'b0}}, r_work[WIDTH-1] ^ w_v};
      FN_ADD, FN_SUB: w_fin_ovf    = w_v;
      FN_AND, FN_OR:  ;
      default:        w_fin_result = '0;
    endcase
  end

  // Control FSM, bit-serial datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_work         <= '0;
      r_funct        <= '0;
      r_carry        <= 1'b0;
      r_cin_msb      <= 1'b0;
      r_illegal_wait <= 1'b0;
      r_done         <= 1'b0;
      r_result       <= '0;
      r_zero         <= 1'b0;
      r_ovf          <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_funct <= funct;
            r_cnt   <= '0;
            r_carry <= uses_borrow(funct);
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            if (is_legal_funct(funct)) begin
              r_state <= ST_RUN;
            end else begin
              // Illegal ops idle one extra cycle so done lands two edges
              // after accept, matching the legacy control timing.
              r_state        <= ST_FINAL;
              r_illegal_wait <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_work[r_cnt] <= w_slice_out;
          r_carry       <= w_slice_cout;
          r_cnt         <= r_cnt + CW'(1);
          if (w_last) begin
            r_cin_msb <= r_carry;
            r_state   <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          if (r_illegal_wait) begin
            r_illegal_wait <= 1'b0;
          end else begin
            r_result <= w_fin_result;
            r_zero   <= (w_fin_result == '0);
            r_ovf    <= w_fin_ovf;
            r_err    <= ~is_legal_funct(r_funct);
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready    = (r_state == ST_IDLE);
  assign done     = r_done;
  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_ovf;
  assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_driver.sv
// ============================================================================
// Module   : tb_serial_alu_driver
// Brief    : Self-checking bench for serial_alu_driver (WIDTH=32) with a
//            word-level arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_alu_driver;

  localparam int W = 32;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [5:0]   funct = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  serial_alu_driver #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .funct    (funct),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: plain arithmetic and signed comparison.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [5:0] f, output logic [W-1:0] r,
                                output logic ov, output logic er);
    r  = '0;
    ov = 1'b0;
    er = 1'b0;
    case (f)
      F_AND: r = a & b;
      F_OR:  r = a | b;
      F_ADD: begin
        r  = a + b;
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      F_SUB: begin
        r  = a - b;
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      F_SLT: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: er = 1'b1;
    endcase
  endfunction

  // One complete operation: accept, optional stray start mid-RUN, wait for
  // done within a bound, then compare everything against the model.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [5:0] f, input bit poke);
    logic [W-1:0] er;
    logic eo, ee;
    int edges, lat;
    model(a, b, f, er, eo, ee);
    lat = ee ? 2 : W + 1;
    chk("ready_before_accept", 64'(ready), 64'(1));
    op_a = a; op_b = b; funct = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; funct = 6'($urandom);
    chk("busy_after_accept", 64'(ready), 64'(0));
    chk("err_cleared_on_accept", 64'(err), 64'(0));
    chk("ovf_cleared_on_accept", 64'(overflow), 64'(0));
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (poke && edges == 5) start = 1'b1;
      if (poke && edges == 7) start = 1'b0;
    end
    start = 1'b0;
    chk("done_latency", 64'(edges), 64'(lat));
    chk("result", 64'(result), 64'(er));
    chk("zero", 64'(zero), 64'(er == '0));
    chk("overflow", 64'(overflow), 64'(eo));
    chk("err", 64'(err), 64'(ee));
    @(posedge clk); #1;
    chk("done_single_cycle", 64'(done), 64'(0));
    chk("result_held", 64'(result), 64'(er));
    chk("ready_after_done", 64'(ready), 64'(1));
  endtask

  initial begin
    int dcount;
    logic [5:0] fsel [5];
    fsel[0] = F_AND; fsel[1] = F_OR; fsel[2] = F_ADD; fsel[3] = F_SUB; fsel[4] = F_SLT;

    // Reset state, observed while rst_n is still low.
    #2;
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(32'h7FFFFFFF, 32'h00000001, F_ADD, 1'b0);
    run_op(32'h00000005, 32'h00000005, F_SUB, 1'b0);
    run_op(32'h80000000, 32'h00000001, F_SUB, 1'b0);
    run_op(32'hFFFFFFFF, 32'h00000001, F_SLT, 1'b0);
    run_op(32'h7FFFFFFF, 32'h80000000, F_SLT, 1'b0);
    run_op(32'h00000003, 32'h00000003, F_SLT, 1'b0);
    run_op(32'hF0F0F0F0, 32'h0FF00FF0, F_AND, 1'b0);
    run_op(32'hF0F0F0F0, 32'h0FF00FF0, F_OR, 1'b0);
    run_op(32'h12345678, 32'h9ABCDEF0, 6'b111111, 1'b0);
    run_op(32'h00000001, 32'h00000002, F_ADD, 1'b0);
    run_op(32'h40000000, 32'h40000000, F_ADD, 1'b1);

    // Reset mid-RUN: asynchronous clear, no done, next op still correct.
    op_a = 32'h12345678; op_b = 32'h11111111; funct = F_ADD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_rst_ready", 64'(ready), 64'(1));
    chk("midrun_rst_done", 64'(done), 64'(0));
    chk("midrun_rst_result", 64'(result), 64'(0));
    chk("midrun_rst_zero", 64'(zero), 64'(0));
    chk("midrun_rst_ovf", 64'(overflow), 64'(0));
    chk("midrun_rst_err", 64'(err), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("no_done_after_abort", 64'(dcount), 64'(0));
    run_op(32'h12345678, 32'h11111111, F_ADD, 1'b0);

    // Randomized operations, occasionally illegal, some with stray start.
    for (int i = 0; i < 40; i++) begin
      logic [5:0] f;
      if ($urandom_range(0, 9) == 0) f = 6'b111111;
      else f = fsel[$urandom_range(0, 4)];
      run_op($urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, f,
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
